// File: rtl/lookup3_pkg.sv
// Shared lookup3 constants: golden initval, mix/final rotation tables, FSM and step-mode encodings.
// Pure definitions, no state or timing; backpressure not applicable.
package lookup3_pkg;

  localparam logic [31:0] LOOKUP3_GOLDEN = 32'hdeadbeef;
  localparam int          MIX_STEPS      = 6;
  localparam int          FINAL_STEPS    = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ABSORB = 3'd1,
    ST_MIX    = 3'd2,
    ST_FINAL  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic {
    MODE_MIX   = 1'b0,
    MODE_FINAL = 1'b1
  } mode_t;

  function automatic logic [4:0] mix_rot(input logic [2:0] step);
    case (step)
      3'd0:    return 5'd4;
      3'd1:    return 5'd6;
      3'd2:    return 5'd8;
      3'd3:    return 5'd16;
      3'd4:    return 5'd19;
      default: return 5'd4;
    endcase
  endfunction

  function automatic logic [4:0] final_rot(input logic [2:0] step);
    case (step)
      3'd0:    return 5'd14;
      3'd1:    return 5'd11;
      3'd2:    return 5'd25;
      3'd3:    return 5'd16;
      3'd4:    return 5'd4;
      3'd5:    return 5'd14;
      default: return 5'd24;
    endcase
  endfunction

  // Every rotation amount in both tables is non-zero, so the right shift never reaches 32.
  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] r);
    return (x << r) | (x >> (6'd32 - {1'b0, r}));
  endfunction

endpackage

// File: rtl/lookup3_step.sv
// One lookup3 mix() or final() sub-step on (a,b,c), selected by mode and step index.
// Purely combinational, zero latency; no handshake, so no backpressure.
module lookup3_step
  import lookup3_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  mode_t       mode,
  input  logic [2:0]  step,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] c_next
);

  logic [1:0] phase;
  logic [4:0] rot;

  // Both sequences cycle through the same three register roles every three steps.
  always_comb begin
    case (step)
      3'd0, 3'd3, 3'd6: phase = 2'd0;
      3'd1, 3'd4:       phase = 2'd1;
      default:          phase = 2'd2;
    endcase
    rot    = (mode == MODE_MIX) ? mix_rot(step) : final_rot(step);
    a_next = a;
    b_next = b;
    c_next = c;
    if (mode == MODE_MIX) begin
      case (phase)
        2'd0: begin
          a_next = (a - c) ^ rotl(c, rot);
          c_next = c + b;
        end
        2'd1: begin
          b_next = (b - a) ^ rotl(a, rot);
          a_next = a + c;
        end
        default: begin
          c_next = (c - b) ^ rotl(b, rot);
          b_next = b + a;
        end
      endcase
    end else begin
      case (phase)
        2'd0:    c_next = (c ^ b) - rotl(b, rot);
        2'd1:    a_next = (a ^ c) - rotl(c, rot);
        default: b_next = (b ^ a) - rotl(a, rot);
      endcase
    end
  end

endmodule

// File: rtl/lookup3_hashword_stream.sv
// Streaming lookup3 hashword2(): absorbs key words 3 at a time, mixes between blocks, finalises the tail.
// Latency N + 6*floor((N-1)/3) + 7 clk (UNROLL=0); s_ready stalls freely, result held until m_ready.
module lookup3_hashword_stream
  import lookup3_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter bit UNROLL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      cmd_pc,
  input  logic [31:0]      cmd_pb,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_hash_c,
  output logic [31:0]      m_hash_b
);

  state_t           state;
  logic [31:0]      a, b, c;
  logic [LEN_W-1:0] rem;
  logic [1:0]       pos;
  logic [2:0]       stp;
  logic [31:0]      sa, sb, sc;
  logic [31:0]      init_v;
  logic             step_last;

  assign init_v    = LOOKUP3_GOLDEN + 32'({cmd_len, 2'b00}) + cmd_pc;
  assign step_last = UNROLL ||
                     ((state == ST_FINAL) ? (stp == 3'(FINAL_STEPS - 1))
                                          : (stp == 3'(MIX_STEPS - 1)));

  if (UNROLL) begin : g_unroll
    logic [31:0] ma [0:MIX_STEPS];
    logic [31:0] mb [0:MIX_STEPS];
    logic [31:0] mc [0:MIX_STEPS];
    logic [31:0] fa [0:FINAL_STEPS];
    logic [31:0] fb [0:FINAL_STEPS];
    logic [31:0] fc [0:FINAL_STEPS];

    assign ma[0] = a;
    assign mb[0] = b;
    assign mc[0] = c;
    assign fa[0] = a;
    assign fb[0] = b;
    assign fc[0] = c;

    for (genvar i = 0; i < MIX_STEPS; i++) begin : g_mix
      lookup3_step u_step (
        .a(ma[i]), .b(mb[i]), .c(mc[i]), .mode(MODE_MIX), .step(3'(i)),
        .a_next(ma[i+1]), .b_next(mb[i+1]), .c_next(mc[i+1])
      );
    end

    for (genvar i = 0; i < FINAL_STEPS; i++) begin : g_final
      lookup3_step u_step (
        .a(fa[i]), .b(fb[i]), .c(fc[i]), .mode(MODE_FINAL), .step(3'(i)),
        .a_next(fa[i+1]), .b_next(fb[i+1]), .c_next(fc[i+1])
      );
    end

    assign sa = (state == ST_FINAL) ? fa[FINAL_STEPS] : ma[MIX_STEPS];
    assign sb = (state == ST_FINAL) ? fb[FINAL_STEPS] : mb[MIX_STEPS];
    assign sc = (state == ST_FINAL) ? fc[FINAL_STEPS] : mc[MIX_STEPS];
  end else begin : g_iter
    mode_t mode;
    assign mode = (state == ST_FINAL) ? MODE_FINAL : MODE_MIX;

    lookup3_step u_step (
      .a(a), .b(b), .c(c), .mode(mode), .step(stp),
      .a_next(sa), .b_next(sb), .c_next(sc)
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      rem       <= '0;
      pos       <= '0;
      stp       <= '0;
      m_hash_c  <= '0;
      m_hash_b  <= '0;
      m_valid   <= 1'b0;
      s_ready   <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            a         <= init_v;
            b         <= init_v;
            c         <= init_v + cmd_pb;
            rem       <= cmd_len;
            pos       <= '0;
            cmd_ready <= 1'b0;
            // An empty key skips final() entirely, matching hashword2() case 0.
            if (cmd_len == '0) begin
              state    <= ST_DONE;
              m_valid  <= 1'b1;
              m_hash_c <= init_v + cmd_pb;
              m_hash_b <= init_v;
            end else begin
              state   <= ST_ABSORB;
              s_ready <= 1'b1;
            end
          end
        end
        ST_ABSORB: begin
          if (s_valid && s_ready) begin
            case (pos)
              2'd0:    a <= a + s_data;
              2'd1:    b <= b + s_data;
              default: c <= c + s_data;
            endcase
            rem <= rem - LEN_W'(1);
            // The last word goes straight to final(), so a full last block is never mixed.
            if (rem == LEN_W'(1)) begin
              state   <= ST_FINAL;
              s_ready <= 1'b0;
              stp     <= '0;
            end else if (pos == 2'd2) begin
              state   <= ST_MIX;
              s_ready <= 1'b0;
              pos     <= '0;
              stp     <= '0;
            end else begin
              pos <= pos + 2'd1;
            end
          end
        end
        ST_MIX: begin
          a <= sa;
          b <= sb;
          c <= sc;
          if (step_last) begin
            stp     <= '0;
            state   <= ST_ABSORB;
            s_ready <= 1'b1;
          end else begin
            stp <= stp + 3'd1;
          end
        end
        ST_FINAL: begin
          a <= sa;
          b <= sb;
          c <= sc;
          if (step_last) begin
            stp      <= '0;
            state    <= ST_DONE;
            m_valid  <= 1'b1;
            m_hash_c <= sc;
            m_hash_b <= sb;
          end else begin
            stp <= stp + 3'd1;
          end
        end
        ST_DONE: begin
          if (m_ready) begin
            m_valid   <= 1'b0;
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lookup3_hashword_stream.sv
// Directed bench for both UNROLL builds against a C-style hashword2() model and fixed constants.
module tb_lookup3_hashword_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0]        cmd_valid, cmd_ready, s_valid, s_ready, m_valid, m_ready;
  logic [1:0][15:0]  cmd_len;
  logic [1:0][31:0]  cmd_pc, cmd_pb, s_data, m_hash_c, m_hash_b;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] key [32];
  int          lens [6] = '{1, 2, 3, 4, 6, 7};

  logic [31:0] r_hc, r_hb;
  int          r_lat;
  bit          r_timeout, r_saw_sready, r_cmdrdy_bad, r_unstable;

  lookup3_hashword_stream #(.LEN_W(16), .UNROLL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_len(cmd_len[0]),
    .cmd_pc(cmd_pc[0]), .cmd_pb(cmd_pb[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .m_hash_c(m_hash_c[0]), .m_hash_b(m_hash_b[0])
  );

  lookup3_hashword_stream #(.LEN_W(16), .UNROLL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_len(cmd_len[1]),
    .cmd_pc(cmd_pc[1]), .cmd_pb(cmd_pb[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .m_hash_c(m_hash_c[1]), .m_hash_b(m_hash_b[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rot(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  // Straight transcription of hashword2() from lookup3.c.
  task automatic ref_hash(input int n, input logic [31:0] pc, input logic [31:0] pb,
                          output logic [31:0] hc, output logic [31:0] hb);
    logic [31:0] a, b, c;
    int len, i;
    a = 32'hdeadbeef + (32'(n) << 2) + pc;
    b = a;
    c = a + pb;
    len = n;
    i = 0;
    while (len > 3) begin
      a += key[i]; b += key[i+1]; c += key[i+2];
      a -= c; a ^= rot(c, 4);  c += b;
      b -= a; b ^= rot(a, 6);  a += c;
      c -= b; c ^= rot(b, 8);  b += a;
      a -= c; a ^= rot(c, 16); c += b;
      b -= a; b ^= rot(a, 19); a += c;
      c -= b; c ^= rot(b, 4);  b += a;
      len -= 3;
      i += 3;
    end
    if (len == 3) c += key[i+2];
    if (len >= 2) b += key[i+1];
    if (len >= 1) begin
      a += key[i];
      c ^= b; c -= rot(b, 14);
      a ^= c; a -= rot(c, 11);
      b ^= a; b -= rot(a, 25);
      c ^= b; c -= rot(b, 16);
      a ^= c; a -= rot(c, 4);
      b ^= a; b -= rot(a, 14);
      c ^= b; c -= rot(b, 24);
    end
    hc = c;
    hb = b;
  endtask

  // Rising edges after the command handshake edge until m_valid is seen high.
  function automatic int exp_lat(input int u, input int n);
    if (n == 0) return 0;
    if (u == 0) return n + 6 * ((n - 1) / 3) + 7;
    return n + ((n - 1) / 3) + 1;
  endfunction

  task automatic do_hash(input int u, input int n, input logic [31:0] pc, input logic [31:0] pb,
                         input bit gaps, input int hold);
    int idx, guard;
    bit hs;
    r_timeout = 0; r_saw_sready = 0; r_cmdrdy_bad = 0; r_unstable = 0;
    cmd_len[u] = 16'(n);
    cmd_pc[u] = pc;
    cmd_pb[u] = pb;
    cmd_valid[u] = 1'b1;
    guard = 0;
    while (!cmd_ready[u] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) r_timeout = 1;
    @(posedge clk); #1;
    cmd_valid[u] = 1'b0;
    if (s_ready[u] && n == 0) r_saw_sready = 1;
    idx = 0;
    r_lat = 0;
    while (!m_valid[u] && r_lat < 3000) begin
      if (cmd_ready[u]) r_cmdrdy_bad = 1;
      if (s_ready[u]) r_saw_sready = 1;
      s_valid[u] = (idx < n) && (!gaps || $urandom_range(0, 1) == 1);
      s_data[u] = key[idx];
      hs = s_valid[u] && s_ready[u];
      @(posedge clk); #1;
      r_lat++;
      if (hs) idx++;
    end
    s_valid[u] = 1'b0;
    if (!m_valid[u]) r_timeout = 1;
    r_hc = m_hash_c[u];
    r_hb = m_hash_b[u];
    repeat (hold) begin
      @(posedge clk); #1;
      if (!m_valid[u] || m_hash_c[u] !== r_hc || m_hash_b[u] !== r_hb || cmd_ready[u])
        r_unstable = 1;
    end
    m_ready[u] = 1'b1;
    @(posedge clk); #1;
    m_ready[u] = 1'b0;
  endtask

  task automatic run_and_check(input int u, input int n, input logic [31:0] pc, input logic [31:0] pb,
                               input bit gaps, input int hold, input bit chk_lat, input string tag);
    logic [31:0] ec, eb;
    ref_hash(n, pc, pb, ec, eb);
    do_hash(u, n, pc, pb, gaps, hold);
    check({tag, " timeout"}, 32'(r_timeout), 32'd0);
    check({tag, " hash_c"}, r_hc, ec);
    check({tag, " hash_b"}, r_hb, eb);
    check({tag, " cmd_ready_busy"}, 32'(r_cmdrdy_bad), 32'd0);
    check({tag, " handoff"}, {30'd0, m_valid[u], cmd_ready[u]}, 32'd1);
    if (chk_lat) check({tag, " latency"}, 32'(r_lat), 32'(exp_lat(u, n)));
    if (hold > 0) check({tag, " hold_stable"}, 32'(r_unstable), 32'd0);
  endtask

  initial begin
    int  guard, n;
    bit  gaps, flag;
    logic [31:0] pc, pb;

    rst = 1'b1;
    cmd_valid = '0; s_valid = '0; m_ready = '0;
    cmd_len = '0; cmd_pc = '0; cmd_pb = '0; s_data = '0;
    for (int i = 0; i < 32; i++) key[i] = 32'(i);

    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d rst m_valid", u), 32'(m_valid[u]), 32'd0);
      check($sformatf("u%0d rst s_ready", u), 32'(s_ready[u]), 32'd0);
      check($sformatf("u%0d rst hash_c", u), m_hash_c[u], 32'd0);
      check($sformatf("u%0d rst hash_b", u), m_hash_b[u], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++)
      check($sformatf("u%0d post-rst cmd_ready", u), 32'(cmd_ready[u]), 32'd1);

    for (int u = 0; u < 2; u++) begin
      // Empty keys: the result is just the initval arithmetic.
      do_hash(u, 0, 32'd0, 32'd0, 1'b0, 0);
      check($sformatf("u%0d len0 hash_c", u), r_hc, 32'hdeadbeef);
      check($sformatf("u%0d len0 hash_b", u), r_hb, 32'hdeadbeef);
      check($sformatf("u%0d len0 latency", u), 32'(r_lat), 32'd0);
      check($sformatf("u%0d len0 s_ready", u), 32'(r_saw_sready), 32'd0);
      do_hash(u, 0, 32'd1, 32'd1, 1'b0, 0);
      check($sformatf("u%0d len0 pc1 hash_c", u), r_hc, 32'hdeadbef1);
      check($sformatf("u%0d len0 pb1 hash_b", u), r_hb, 32'hdeadbef0);

      for (int i = 0; i < 32; i++) key[i] = 32'(i);
      for (int j = 0; j < 6; j++)
        run_and_check(u, lens[j], 32'd0, 32'd0, 1'b0, 0, 1'b1, $sformatf("u%0d len%0d", u, lens[j]));
      run_and_check(u, 7, 32'd0, 32'd0, 1'b1, 10, 1'b0, $sformatf("u%0d gaps len7", u));

      // Abort after two of five words, then a fresh two-word command.
      cmd_len[u] = 16'd5; cmd_pc[u] = 32'd0; cmd_pb[u] = 32'd0; cmd_valid[u] = 1'b1;
      guard = 0;
      while (!cmd_ready[u] && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      @(posedge clk); #1;
      cmd_valid[u] = 1'b0;
      s_valid[u] = 1'b1; s_data[u] = 32'h100;
      @(posedge clk); #1;
      s_data[u] = 32'h101;
      @(posedge clk); #1;
      s_valid[u] = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check($sformatf("u%0d abort m_valid", u), 32'(m_valid[u]), 32'd0);
      check($sformatf("u%0d abort s_ready", u), 32'(s_ready[u]), 32'd0);
      check($sformatf("u%0d abort hash_c", u), m_hash_c[u], 32'd0);
      flag = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (m_valid[u]) flag = 1;
      end
      check($sformatf("u%0d abort no m_valid", u), 32'(flag), 32'd0);
      check($sformatf("u%0d abort cmd_ready", u), 32'(cmd_ready[u]), 32'd1);
      key[0] = 32'h200; key[1] = 32'h201;
      run_and_check(u, 2, 32'd0, 32'd0, 1'b0, 0, 1'b1, $sformatf("u%0d after abort len2", u));

      for (int k = 0; k < 100; k++) begin
        n = int'($urandom_range(0, 20));
        for (int i = 0; i < 32; i++) key[i] = $urandom;
        pc = $urandom;
        pb = $urandom;
        gaps = 1'($urandom_range(0, 1));
        run_and_check(u, n, pc, pb, gaps, int'($urandom_range(0, 2)), !gaps,
                      $sformatf("u%0d rand%0d len%0d", u, k, n));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
